// File: rtl/muldiv_unit_mc.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_mc
// Purpose  : Iterative RV32M/RV64M multiply/divide unit for the multicycle
//            core. Decodes op/funct3/funct7 locally and produces one result
//            bit per cycle: shift-add multiply or restoring divide.
// Ports    : clk      - clock, rising edge
//            reset_n  - synchronous reset, active-low
//            start    - request, honoured only while idle
//            kill     - abort the operation in flight (pipeline flush)
//            op       - instruction opcode
//            funct3   - M-extension operation select
//            funct7   - must be 7'b0000001 for M-extension
//            a, b     - rs1 / rs2 operands, captured when start is accepted
//            md_sel   - combinational decode: this is an M-extension op
//            busy     - high in every state except IDLE
//            done     - one-cycle pulse, result valid
//            result   - last completed result, held until the next one
// Params   : XLEN     - operand width, power of two, >= 8
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit_mc #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            kill,
   input  logic [6:0]      op,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            md_sel,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int              CW      = $clog2(XLEN) + 1;
   localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_ITER = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t state, next_state;

   // Operand/command capture; after PREP, b_q holds the multiplicand or
   // divisor magnitude.
   logic [XLEN-1:0]   a_q, b_q;
   logic [2:0]        f3_q;
   logic              neg_q;
   logic [CW-1:0]     count;
   // Multiply: {high partial, multiplier shifting out}.
   // Divide:   {remainder, dividend shifting out / quotient shifting in}.
   logic [2*XLEN-1:0] acc;

   assign md_sel = (op == 7'b0110011) && (funct7 == 7'b0000001);
   assign busy   = (state != S_IDLE);
   assign done   = (state == S_DONE);

   // ---------------- PREP decode ----------------
   logic            is_div, sign_a_en, sign_b_en, a_neg, b_neg, neg_res;
   logic [XLEN-1:0] mag_a, mag_b;
   logic            special;
   logic [XLEN-1:0] special_val;

   assign is_div    = f3_q[2];
   // Signed division uses both signs; MULH both, MULHSU only rs1. MUL low
   // half is sign-agnostic, so it runs unsigned.
   assign sign_a_en = is_div ? ~f3_q[0] : (f3_q[1:0] == 2'b01 || f3_q[1:0] == 2'b10);
   assign sign_b_en = is_div ? ~f3_q[0] : (f3_q[1:0] == 2'b01);
   assign a_neg     = sign_a_en & a_q[XLEN-1];
   assign b_neg     = sign_b_en & b_q[XLEN-1];
   assign mag_a     = a_neg ? -a_q : a_q;
   assign mag_b     = b_neg ? -b_q : b_q;
   // Remainder takes the dividend's sign; quotient and products take the xor.
   assign neg_res   = (is_div && f3_q[1]) ? a_neg : (a_neg ^ b_neg);

   always_comb begin
      special     = 1'b0;
      special_val = '0;
      if (is_div) begin
         if (b_q == '0) begin
            special     = 1'b1;
            special_val = f3_q[1] ? a_q : '1;
         end else if (!f3_q[0] && a_q == MIN_INT && b_q == '1) begin
            special     = 1'b1;
            special_val = f3_q[1] ? '0 : a_q;
         end
      end
   end

   // ---------------- ITER step ----------------
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_shift;
   logic              div_ge;
   logic [XLEN-1:0]   div_diff;
   logic [2*XLEN-1:0] div_next;

   assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
   assign mul_next  = {mul_sum, acc[XLEN-1:1]};

   assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
   assign div_ge    = (div_shift >= {1'b0, b_q});
   // The true difference is below the divisor, so XLEN bits suffice.
   assign div_diff  = div_shift[XLEN-1:0] - b_q;
   assign div_next  = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1}
                             : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};

   // ---------------- FIX ----------------
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   div_sel, fix_val;

   assign prod_fix = neg_q ? -acc : acc;
   assign div_sel  = f3_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
   always_comb begin
      fix_val = '0;
      if (f3_q[2])
         fix_val = neg_q ? -div_sel : div_sel;
      else if (f3_q[1:0] == 2'b00)
         fix_val = prod_fix[XLEN-1:0];
      else
         fix_val = prod_fix[2*XLEN-1:XLEN];
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: if (start && md_sel && !kill) next_state = S_PREP;
         S_PREP: begin
            if (kill)         next_state = S_IDLE;
            else if (special) next_state = S_DONE;
            else              next_state = S_ITER;
         end
         S_ITER: begin
            if (kill)               next_state = S_IDLE;
            else if (count == LAST) next_state = S_FIX;
         end
         S_FIX:  next_state = kill ? S_IDLE : S_DONE;
         S_DONE: next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // ---------------- Datapath ----------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         a_q    <= '0;
         b_q    <= '0;
         f3_q   <= '0;
         neg_q  <= 1'b0;
         count  <= '0;
         acc    <= '0;
         result <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (next_state == S_PREP) begin
                  a_q  <= a;
                  b_q  <= b;
                  f3_q <= funct3;
               end
            end
            S_PREP: begin
               b_q   <= mag_b;
               acc   <= {{XLEN{1'b0}}, mag_a};
               neg_q <= neg_res;
               count <= '0;
               if (next_state == S_DONE) result <= special_val;
            end
            S_ITER: begin
               acc   <= is_div ? div_next : mul_next;
               count <= count + 1'b1;
            end
            S_FIX: begin
               // A kill here must leave the previous result intact.
               if (next_state == S_DONE) result <= fix_val;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit_mc
// Purpose  : Self-checking bench for muldiv_unit_mc (XLEN=32): directed
//            cases with literal expectations plus randomized traffic checked
//            every cycle against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit_mc;

   localparam int          XLEN = 32;
   localparam int          LAT  = XLEN + 3;
   localparam logic [6:0]  OP_R = 7'b0110011;
   localparam logic [31:0] MINV = 32'h80000000;

   logic        clk = 1'b0;
   logic        reset_n, start, kill;
   logic [6:0]  op, funct7;
   logic [2:0]  funct3;
   logic [31:0] a, b;
   logic        md_sel, busy, done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   muldiv_unit_mc #(.XLEN(XLEN)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .kill(kill),
      .op(op), .funct3(funct3), .funct7(funct7), .a(a), .b(b),
      .md_sel(md_sel), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      longint          sx = longint'($signed(x));
      longint          sy = longint'($signed(y));
      longint unsigned ux = {32'b0, x};
      longint unsigned uy = {32'b0, y};
      logic [63:0]     p;
      int              xi = $signed(x);
      int              yi = $signed(y);
      case (f)
         3'd0: begin p = sx * sy; return p[31:0];  end
         3'd1: begin p = sx * sy; return p[63:32]; end
         3'd2: begin p = sx * longint'(uy); return p[63:32]; end
         3'd3: begin p = ux * uy; return p[63:32]; end
         3'd4: begin
            if (y == 0) return 32'hFFFFFFFF;
            if (x == MINV && y == 32'hFFFFFFFF) return x;
            return 32'(xi / yi);
         end
         3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
         3'd6: begin
            if (y == 0) return x;
            if (x == MINV && y == 32'hFFFFFFFF) return 32'h0;
            return 32'(xi % yi);
         end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      return f[2] && (y == 0 || (!f[0] && x == MINV && y == 32'hFFFFFFFF));
   endfunction

   function automatic bit exp_sel();
      return (op == OP_R) && (funct7 == 7'b0000001);
   endfunction

   // m_cnt: busy cycles remaining including the current one; 1 = done cycle.
   int          m_cnt  = 0;
   bit          m_init = 0;
   logic [31:0] m_res  = '0;
   logic [31:0] m_pend = '0;

   always @(posedge clk) begin
      if (!reset_n) begin
         m_init = 1;
         m_cnt  = 0;
         m_res  = '0;
      end else if (m_cnt > 0) begin
         if (kill) m_cnt = 0;
         else begin
            m_cnt--;
            if (m_cnt == 1) m_res = m_pend;
         end
      end else if (start && exp_sel() && !kill) begin
         m_pend = ref_res(funct3, a, b);
         m_cnt  = is_special(funct3, a, b) ? 2 : LAT;
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         check("busy", busy, m_cnt > 0);
         check("done", done, m_cnt == 1);
         check("md_sel", md_sel, exp_sel());
         if (m_cnt <= 1) check("result", result, m_res);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Waits for idle, presents the op, returns in cycle k+1.
   task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      int g = 0;
      while (busy && g < 200) begin step(1); g++; end
      op = OP_R; funct7 = 7'h01; funct3 = f; a = x; b = y; start = 1'b1;
      step(1);
      start = 1'b0; a = $urandom; b = $urandom;
   endtask

   task automatic wait_done(input string nm, input logic [31:0] exp, input int lat);
      int c = 1;
      while (!done && c < 200) begin step(1); c++; end
      check({nm, " latency"}, c, lat);
      check({nm, " result"}, result, exp);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return MINV;
         4: return 32'h7FFFFFFF;
         5: return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      reset_n = 0; start = 0; kill = 0; op = OP_R; funct7 = 7'h01;
      funct3 = 0; a = 0; b = 0;
      step(3);
      reset_n = 1;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset result", result, 0);

      // Multiply
      issue(3'd0, 32'd7, 32'hFFFFFFFD);           wait_done("MUL 7*-3", 32'hFFFFFFEB, LAT);
      issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);     wait_done("MULHU", 32'hFFFFFFFE, LAT);
      issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);     wait_done("MULH", 32'h0, LAT);
      issue(3'd2, 32'hFFFFFFFF, 32'd2);            wait_done("MULHSU", 32'hFFFFFFFF, LAT);
      // Divide
      issue(3'd4, 32'hFFFFFFF9, 32'd2);            wait_done("DIV -7/2", 32'hFFFFFFFD, LAT);
      issue(3'd6, 32'hFFFFFFF9, 32'd2);            wait_done("REM -7/2", 32'hFFFFFFFF, LAT);
      issue(3'd5, 32'd100, 32'd7);                 wait_done("DIVU", 32'd14, LAT);
      issue(3'd7, 32'd100, 32'd7);                 wait_done("REMU", 32'd2, LAT);
      // Special divides
      issue(3'd4, 32'd5, 32'd0);                   wait_done("DIV by 0", 32'hFFFFFFFF, 2);
      issue(3'd6, 32'd5, 32'd0);                   wait_done("REM by 0", 32'd5, 2);
      issue(3'd4, MINV, 32'hFFFFFFFF);             wait_done("DIV ovf", MINV, 2);
      issue(3'd6, MINV, 32'hFFFFFFFF);             wait_done("REM ovf", 32'h0, 2);

      // Start while busy is ignored
      issue(3'd0, 32'd7, 32'hFFFFFFFD);
      step(9);
      funct3 = 3'd5; a = 32'd9; b = 32'd3; start = 1'b1;
      step(1);
      start = 1'b0;
      begin
         int c = 11;
         while (!done && c < 200) begin step(1); c++; end
         check("busy start latency", c, LAT);
         check("busy start result", result, 32'hFFFFFFEB);
      end

      // Kill mid-operation: idle next cycle, no done, result kept
      issue(3'd5, 32'd1000, 32'd3);
      step(19);
      kill = 1'b1;
      step(1);
      kill = 1'b0;
      check("kill busy", busy, 0);
      begin
         int dn = 0;
         repeat (40) begin step(1); if (done) dn++; end
         check("kill no done", dn, 0);
         check("kill result kept", result, 32'hFFFFFFEB);
      end

      // kill and start together in IDLE
      funct3 = 3'd0; a = 32'd3; b = 32'd3; start = 1'b1; kill = 1'b1;
      step(1);
      start = 1'b0; kill = 1'b0;
      check("kill+start busy", busy, 0);

      // Reset mid-operation
      issue(3'd1, 32'h12345678, 32'h9ABCDEF0);
      step(14);
      reset_n = 1'b0;
      step(1);
      reset_n = 1'b1;
      check("mid reset busy", busy, 0);
      check("mid reset result", result, 0);

      // Non-M instruction is not accepted
      funct7 = 7'h00; funct3 = 3'd0; a = 32'd5; b = 32'd6; start = 1'b1;
      #1;
      check("md_sel f7=0", md_sel, 0);
      step(1);
      start = 1'b0; funct7 = 7'h01;
      check("f7=0 no accept", busy, 0);

      // Randomized traffic
      for (int i = 0; i < 20000; i++) begin
         step(1);
         start   = ($urandom_range(0, 99) < 40);
         kill    = ($urandom_range(0, 149) == 0);
         reset_n = ($urandom_range(0, 2999) != 0);
         op      = ($urandom_range(0, 9) == 0) ? 7'b0010011 : OP_R;
         funct7  = ($urandom_range(0, 9) == 0) ? 7'h20 : 7'h01;
         funct3  = 3'($urandom_range(0, 7));
         a       = pick();
         b       = pick();
      end
      start = 0; kill = 0; reset_n = 1;
      step(LAT + 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
